// File: rtl/clock_pkg.sv
// Shared definitions for the clock front-end: load-key FSM encoding and switch BCD field layout.
package clock_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle        = 3'd0;
    localparam state_t StPressWait   = 3'd1;
    localparam state_t StCheck       = 3'd2;
    localparam state_t StHeld        = 3'd3;
    localparam state_t StReleaseWait = 3'd4;

    // Low bit of each 4-bit BCD digit within switch[17:2]
    localparam int HrsMsbLo = 14;
    localparam int HrsLsbLo = 10;
    localparam int MinMsbLo = 6;
    localparam int MinLsbLo = 2;

    localparam logic [3:0] DigitMax = 4'd9;
    localparam logic [3:0] TensMax  = 4'd5;

endpackage

// File: rtl/load_key_conditioner_if.sv
// Key/switch inputs and conditioned outputs of the load-key front-end.
interface load_key_conditioner_if;

    logic        nKey_i;
    logic [17:2] switch_i;
    logic [17:2] switch_o;
    logic        nLoadNow_o;
    logic        loadError_o;

    modport master (
        output nKey_i,
        output switch_i,
        input  switch_o,
        input  nLoadNow_o,
        input  loadError_o
    );

    modport slave (
        input  nKey_i,
        input  switch_i,
        output switch_o,
        output nLoadNow_o,
        output loadError_o
    );

endinterface

// File: rtl/sync2_ff.sv
// Two-flop synchronizer of configurable width with a configurable asynchronous reset value.
module sync2_ff #(
    parameter int unsigned         Width    = 1,
    parameter logic [Width-1:0]    ResetVal = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [Width-1:0] i_d,
    output logic [Width-1:0] o_q
);

    logic [Width-1:0] r_meta;
    logic [Width-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= ResetVal;
            r_sync <= ResetVal;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/load_key_conditioner.sv
// Debounces the LOAD key, snapshots the time-set switches and emits a one-clock load strobe
// for a valid BCD setting, or a one-clock error pulse for an invalid one.
module load_key_conditioner
    import clock_pkg::*;
#(
    parameter int debounce_tc_p   = 999999,
    parameter int hrs_load_min_p  = 0,
    parameter int hrs_load_max_p  = 12,
    parameter int mins_load_max_p = 59
) (
    input logic                   clk_i,
    input logic                   rst_i,
    load_key_conditioner_if.slave bus
);

    localparam int              CntW  = (debounce_tc_p > 0) ? $clog2(debounce_tc_p + 1) : 1;
    localparam logic [CntW-1:0] TcCnt = CntW'(debounce_tc_p);

    logic        w_key_sync;
    logic [17:2] w_sw_sync;

    sync2_ff #(
        .Width    (1),
        .ResetVal (1'b1)
    ) u_key_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (bus.nKey_i),
        .o_q   (w_key_sync)
    );

    sync2_ff #(
        .Width    (16),
        .ResetVal (16'h0000)
    ) u_sw_sync (
        .i_clk (clk_i),
        .i_rst (rst_i),
        .i_d   (bus.switch_i),
        .o_q   (w_sw_sync)
    );

    state_t          r_state;
    state_t          w_state_d;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic [CntW-1:0] w_cnt_inc;
    logic            w_capture;
    logic [17:2]     r_stage;
    logic [17:2]     r_switch;
    logic            r_nload;
    logic            r_load_err;

    // Saturating increment; the counter never wraps past the terminal count
    assign w_cnt_inc = (r_cnt == TcCnt) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_capture = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_d = '0;
                if (!w_key_sync) begin
                    w_state_d = StPressWait;
                end
            end
            StPressWait: begin
                if (w_key_sync) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == TcCnt) begin
                        w_state_d = StCheck;
                        w_capture = 1'b1;
                    end
                end
            end
            StCheck: begin
                w_state_d = StHeld;
                w_cnt_d   = '0;
            end
            StHeld: begin
                w_cnt_d = '0;
                if (w_key_sync) begin
                    w_state_d = StReleaseWait;
                end
            end
            StReleaseWait: begin
                if (!w_key_sync) begin
                    w_state_d = StHeld;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == TcCnt) begin
                        w_state_d = StIdle;
                        w_cnt_d   = '0;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    logic [3:0] w_hrs_msb;
    logic [3:0] w_hrs_lsb;
    logic [3:0] w_min_msb;
    logic [3:0] w_min_lsb;
    int         w_hrs;
    int         w_mins;
    logic       w_valid;

    assign w_hrs_msb = r_stage[HrsMsbLo +: 4];
    assign w_hrs_lsb = r_stage[HrsLsbLo +: 4];
    assign w_min_msb = r_stage[MinMsbLo +: 4];
    assign w_min_lsb = r_stage[MinLsbLo +: 4];

    assign w_hrs  = 10 * int'(w_hrs_msb) + int'(w_hrs_lsb);
    assign w_mins = 10 * int'(w_min_msb) + int'(w_min_lsb);

    assign w_valid = (w_hrs_msb <= DigitMax) && (w_hrs_lsb <= DigitMax) &&
                     (w_hrs >= hrs_load_min_p) && (w_hrs <= hrs_load_max_p) &&
                     (w_min_msb <= TensMax) && (w_min_lsb <= DigitMax) &&
                     (w_mins <= mins_load_max_p);

    // Strobe and error are only ever raised from the single CHECK cycle, so both self-clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stage    <= '0;
            r_switch   <= '0;
            r_nload    <= 1'b1;
            r_load_err <= 1'b0;
        end else begin
            r_nload    <= 1'b1;
            r_load_err <= 1'b0;
            if (w_capture) begin
                r_stage <= w_sw_sync;
            end
            if (r_state == StCheck) begin
                if (w_valid) begin
                    r_switch <= r_stage;
                    r_nload  <= 1'b0;
                end else begin
                    r_load_err <= 1'b1;
                end
            end
        end
    end

    assign bus.switch_o    = r_switch;
    assign bus.nLoadNow_o  = r_nload;
    assign bus.loadError_o = r_load_err;

endmodule
